transpose_pingpong_buf: RTL and testbench
=========================================

TRANSPOSE_PINGPONG_BUF -- requirements
Module: transpose_pingpong_buf

Interface
- REQ-001 Parameter DATA_W, default 25: sample width in bits.
- REQ-002 Parameter N, default 8: block edge, N x N words per block; power of 2, >= 2.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rst_n  input  1  asynchronous, active-low reset.
- REQ-005 s_valid  input  1  input word valid.
- REQ-006 s_ready  output  1  buffer can accept a word.
- REQ-007 s_data  input  DATA_W  input word, row-major order within a block.
- REQ-008 transpose  input  1  1 = column-major read-out, 0 = row-major pass-through.
- REQ-009 m_valid  output  1  output word valid.
- REQ-010 m_ready  input  1  downstream accepts the word.
- REQ-011 m_data  output  DATA_W  output word.
- REQ-012 m_last  output  1  marks the final word (index N*N-1) of a block, qualified by m_valid.

Function
- REQ-013 The block SHALL hold two banks (0, 1), each N*N x DATA_W, with per-bank full flags.
- REQ-014 Write side SHALL accept a word when s_valid && s_ready, storing at write index w (0..N*N-1) of the current write bank.
- REQ-015 s_ready SHALL be 1 exactly when the current write bank's full flag is 0.
- REQ-016 On accepting index N*N-1 the write bank SHALL set full, w SHALL wrap to 0, and the write bank SHALL toggle.
- REQ-017 Read FSM states: IDLE (no bank loaded) and STREAM (emitting from read bank); IDLE->STREAM when the read bank is full.
- REQ-018 transpose SHALL be sampled only on the IDLE->STREAM transition and at each block boundary, and held for the whole block.
- REQ-019 Read index r SHALL map to address (r mod N)*N + r/N when transpose=1, and to r when transpose=0.
- REQ-020 m_data/m_valid/m_last SHALL be registered; the register loads when !m_valid || m_ready.
- REQ-021 m_valid SHALL hold, with m_data stable, until m_ready is sampled high.
- REQ-022 Latency: first m_valid of a block SHALL rise 2 cycles after the edge that accepted its last input word when the read FSM is IDLE.
- REQ-023 With m_ready=1, output SHALL sustain 1 word/cycle, including across block boundaries when the next bank is already full (no bubble).
- REQ-024 Handshake of read index N*N-1 SHALL clear that bank's full flag and toggle the read bank.
- REQ-025 Freeing a bank and the write side filling the other bank on the same edge SHALL both take effect; s_ready SHALL reflect the freed bank on the next cycle.
- REQ-026 Both banks full SHALL force s_ready=0, with no data loss or overwrite.

Reset
- REQ-027 Asserting rst_n low SHALL clear, asynchronously: full flags, w, r, bank selects (to 0), FSM (IDLE), m_valid=0, m_last=0, m_data=0.
- REQ-028 Bank contents SHALL not be reset; a partially written or read block in progress at reset SHALL be discarded.
- REQ-029 After reset release, s_ready SHALL be 1 in the first cycle.

Configuration
- REQ-030 Macro TRANSPOSE_PINGPONG_BUF_BLKCNT_EN defined: add output blk_cnt (16 bits), reset 0, incremented on each m_last handshake, wrapping 65535->0.
- REQ-031 Macro undefined: no blk_cnt port and no counter logic; all other behaviour identical.

Structure
- REQ-032 Shared package tpb_pkg SHALL hold the default DATA_W/N constants, index-width function (log2 of N*N), and the read FSM state typedef.
- REQ-033 One sub-module, tpb_bank (single N*N register-array bank, one write port, one asynchronous read port), SHALL be instantiated twice.

Verification
- REQ-034 N=8, transpose=1, m_ready=1, write 0..63: output 0,8,16..56,1,9..63; m_last only on 63; first m_valid 2 cycles after input 63.
- REQ-035 transpose=0, write 100..163: output 100..163 in order, m_last on 163.
- REQ-036 m_ready=0, s_valid=1 continuous: exactly 128 words accepted, then s_ready=0; releasing m_ready yields 128 words with no bubble at the block boundary.
- REQ-037 Toggle transpose mid-block: current block order unchanged; new mode applies from the next block.
- REQ-038 Assert rst_n low after 30 words of a block: m_valid=0, s_ready=1; a fresh 64-word block then emits correctly.
- REQ-039 With the macro defined, 3 blocks drained: blk_cnt=3; preset near 65535: wraps to 0.

Source files
------------

// File: rtl/tpb_pkg.sv
// Shared constants, index-width helper and read FSM state type for the transpose ping-pong buffer.
// Optional block counter is enabled by defining TRANSPOSE_PINGPONG_BUF_BLKCNT_EN.
package tpb_pkg;

   localparam int unsigned DefDataW = 25;
   localparam int unsigned DefN     = 8;

   // Address width of one N x N bank.
   function automatic int unsigned idx_w(input int unsigned n);
      return $clog2(n * n);
   endfunction

   typedef enum logic {
      StIdle,
      StStream
   } rd_state_e;

endpackage

// File: rtl/tpb_bank.sv
// One N*N word storage bank: synchronous write port, asynchronous read port, contents not reset.
// Part of transpose_pingpong_buf (optional TRANSPOSE_PINGPONG_BUF_BLKCNT_EN does not affect this file).
module tpb_bank
   import tpb_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned N      = DefN,
   localparam int unsigned IW    = idx_w(N)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [N*N];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/transpose_pingpong_buf.sv
// Two-bank N x N block buffer: row-major writes, row- or column-major registered read-out.
// Define TRANSPOSE_PINGPONG_BUF_BLKCNT_EN to add the 16-bit blk_cnt output.
module transpose_pingpong_buf
   import tpb_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned N      = DefN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              transpose,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last
`ifdef TRANSPOSE_PINGPONG_BUF_BLKCNT_EN
   ,
   output logic [15:0]       blk_cnt
`endif
);

   localparam int unsigned IW = idx_w(N);
   localparam int unsigned HW = IW / 2;
   // N*N is a power of two, so the last index is all ones.
   localparam logic [IW-1:0] LastIdx = '1;

   logic [1:0]        full_q, full_d;
   logic              wr_bank_q, rd_bank_q;
   logic [IW-1:0]     w_q, r_q;
   logic              tr_q;
   rd_state_e         state_q;
   logic              m_valid_q, m_last_q;
   logic [DATA_W-1:0] m_data_q;

   logic              wr_en, wr_done, load_en, rd_done;
   logic [IW-1:0]     rd_addr;
   logic [DATA_W-1:0] rdata [2];
   logic [DATA_W-1:0] rd_word;

   assign s_ready = ~full_q[wr_bank_q];
   assign wr_en   = s_valid & s_ready;
   assign wr_done = wr_en & (w_q == LastIdx);
   assign load_en = ~m_valid_q | m_ready;
   assign rd_done = (state_q == StStream) & load_en & (r_q == LastIdx);

   // Transposed read: swap the row and column halves of the index.
   assign rd_addr = tr_q ? {r_q[HW-1:0], r_q[IW-1:HW]} : r_q;
   assign rd_word = rdata[rd_bank_q];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      tpb_bank #(
         .DATA_W(DATA_W),
         .N     (N)
      ) u_bank (
         .clk  (clk),
         .we   (wr_en & (wr_bank_q == 1'(b))),
         .waddr(w_q),
         .wdata(s_data),
         .raddr(rd_addr),
         .rdata(rdata[b])
      );
   end

   // Write completion and read completion always target different banks.
   always_comb begin
      full_d = full_q;
      if (wr_done) full_d[wr_bank_q] = 1'b1;
      if (rd_done) full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q    <= '0;
         w_q       <= '0;
         wr_bank_q <= 1'b0;
      end else begin
         full_q <= full_d;
         if (wr_en) begin
            w_q <= w_q + 1'b1;
            if (wr_done) wr_bank_q <= ~wr_bank_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         r_q       <= '0;
         rd_bank_q <= 1'b0;
         tr_q      <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (load_en) begin
                  m_valid_q <= 1'b0;
                  m_last_q  <= 1'b0;
               end
               if (full_q[rd_bank_q]) begin
                  state_q <= StStream;
                  tr_q    <= transpose;
               end
            end
            StStream: begin
               if (load_en) begin
                  m_data_q  <= rd_word;
                  m_valid_q <= 1'b1;
                  m_last_q  <= (r_q == LastIdx);
                  r_q       <= r_q + 1'b1;
                  if (r_q == LastIdx) begin
                     rd_bank_q <= ~rd_bank_q;
                     tr_q      <= transpose;
                     // Continue without a bubble only if the other bank is already loaded.
                     if (!full_q[~rd_bank_q]) state_q <= StIdle;
                  end
               end
            end
         endcase
      end
   end

   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_data  = m_data_q;

`ifdef TRANSPOSE_PINGPONG_BUF_BLKCNT_EN
   logic [15:0] blk_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt_q <= '0;
      end else if (m_valid_q && m_ready && m_last_q) begin
         blk_cnt_q <= blk_cnt_q + 16'd1;
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_transpose_pingpong_buf.sv
// Directed self-checking bench for transpose_pingpong_buf (N=8, DATA_W=25).
// Blk_cnt checks run only when TRANSPOSE_PINGPONG_BUF_BLKCNT_EN is defined.
module tb_transpose_pingpong_buf;

   localparam int unsigned DATA_W = 25;
   localparam int unsigned N      = 8;
   localparam int unsigned NN     = N * N;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_data = '0;
   logic              transpose = 1'b0;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
`ifdef TRANSPOSE_PINGPONG_BUF_BLKCNT_EN
   logic [15:0]       blk_cnt;
`endif

   transpose_pingpong_buf #(
      .DATA_W(DATA_W),
      .N     (N)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .transpose(transpose),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last)
`ifdef TRANSPOSE_PINGPONG_BUF_BLKCNT_EN
      ,
      .blk_cnt  (blk_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output capture: every m_valid && m_ready handshake, with the cycle it was presented.
   logic [DATA_W-1:0] out_q[$];
   bit                last_q[$];
   int unsigned       stamp_q[$];

   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         out_q.push_back(m_data);
         last_q.push_back(m_last);
         stamp_q.push_back(cyc);
      end
   end

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic clear_capture();
      out_q.delete();
      last_q.delete();
      stamp_q.delete();
   endtask

   // Present one word and hold it until accepted; returns the number of the accepting edge.
   task automatic send_word(input int unsigned v, output int unsigned acc);
      int unsigned t = 0;
      s_valid = 1'b1;
      s_data  = DATA_W'(v);
      @(negedge clk);
      while (!s_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) check("send_timeout", 32'(s_ready), 32'd1);
      acc = cyc + 1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic send_block(input int unsigned base, input int unsigned count);
      int unsigned acc;
      for (int i = 0; i < int'(count); i++) send_word(base + i, acc);
   endtask

   task automatic wait_outputs(input int unsigned n);
      int unsigned t = 0;
      while (out_q.size() < n && t < 2000) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (out_q.size() < n) check("drain_timeout", 32'(out_q.size()), 32'(n));
   endtask

   // Written value at address a is base + a; expected read order depends on mode.
   task automatic check_block(input string tag, input int unsigned base, input bit tr,
                              input int unsigned off);
      int unsigned a;
      for (int i = 0; i < int'(NN); i++) begin
         a = tr ? (32'(i) % N) * N + 32'(i) / N : 32'(i);
         if (off + i < out_q.size()) begin
            check($sformatf("%s_data%0d", tag, i), 32'(out_q[off+i]), base + a);
            check($sformatf("%s_last%0d", tag, i), 32'(last_q[off+i]), 32'(i == int'(NN) - 1));
         end else begin
            check($sformatf("%s_missing%0d", tag, i), 32'(out_q.size()), off + i + 1);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned acc;
      int unsigned vcyc;
      int unsigned n;
      int unsigned t;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;

      // Transposed block 0..63, latency of first output.
      transpose = 1'b1;
      m_ready   = 1'b1;
      clear_capture();
      send_block(0, NN - 1);
      send_word(NN - 1, acc);
      vcyc = 0;
      t    = 0;
      while (vcyc == 0 && t < 50) begin
         @(negedge clk);
         if (m_valid) vcyc = cyc;
         t++;
      end
      check("lat_first_valid", vcyc - acc, 32'd2);
      wait_outputs(NN);
      check_block("tr", 0, 1'b1, 0);
      if (stamp_q.size() >= NN) check("tr_no_gap", stamp_q[NN-1] - stamp_q[0], NN - 1);

      // Row-major pass-through.
      @(posedge clk);
      #1;
      clear_capture();
      transpose = 1'b0;
      send_block(100, NN);
      wait_outputs(NN);
      check_block("pass", 100, 1'b0, 0);

      // Back-pressure: both banks fill, then drain without a boundary bubble.
      @(posedge clk);
      #1;
      clear_capture();
      m_ready = 1'b0;
      s_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         s_data = DATA_W'(200 + n);
         @(negedge clk);
         if (s_ready) n++;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      check("bp_accepted", n, 32'd128);
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_m_valid", 32'(m_valid), 32'd1);
      check("bp_m_data_held", 32'(m_data), 32'd200);
      m_ready = 1'b1;
      wait_outputs(2 * NN);
      check_block("bp0", 200, 1'b0, 0);
      check_block("bp1", 264, 1'b0, NN);
      if (stamp_q.size() >= 2 * NN)
         check("bp_no_gap", stamp_q[2*NN-1] - stamp_q[0], 2 * NN - 1);

      // Mode change mid-block applies only to the next block.
      @(posedge clk);
      #1;
      clear_capture();
      transpose = 1'b1;
      fork
         begin
            send_block(400, NN);
            send_block(500, NN);
         end
         begin
            t = 0;
            while (out_q.size() < 20 && t < 1000) begin
               @(negedge clk);
               #1;
               t++;
            end
            transpose = 1'b0;
         end
      join
      wait_outputs(2 * NN);
      check_block("mode0", 400, 1'b1, 0);
      check_block("mode1", 500, 1'b0, NN);

      // Reset mid-block discards the partial block.
      @(posedge clk);
      #1;
      clear_capture();
      send_block(600, 30);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_m_valid", 32'(m_valid), 32'd0);
      check("mrst_s_ready", 32'(s_ready), 32'd1);
      check("mrst_m_data", 32'(m_data), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_s_ready_rel", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;
      clear_capture();
      transpose = 1'b1;
      send_block(700, NN);
      wait_outputs(NN);
      check_block("post_rst", 700, 1'b1, 0);

`ifdef TRANSPOSE_PINGPONG_BUF_BLKCNT_EN
      clear_capture();
      send_block(800, NN);
      send_block(900, NN);
      wait_outputs(2 * NN);
      @(posedge clk);
      #1;
      check("blk_cnt_3", 32'(blk_cnt), 32'd3);
      force dut.blk_cnt_q = 16'hffff;
      @(posedge clk);
      #1;
      release dut.blk_cnt_q;
      clear_capture();
      send_block(1000, NN);
      wait_outputs(NN);
      @(posedge clk);
      #1;
      check("blk_cnt_wrap", 32'(blk_cnt), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
